// File: rtl/index_packer.sv
// Packs K successive BIT-wide indices into one K*BIT string for the one-hot decoder,
// holding the completed string with a valid flag until the consumer takes it.
module index_packer #(
    parameter int SIZE = 8,
    parameter int BIT  = $clog2(SIZE),
    parameter int K    = 4,
    parameter int FW   = $clog2(K + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BIT-1:0] in_index,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K*BIT-1:0] string_out,
    output logic [FW-1:0]  fill,
    output logic           err
);

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    // One bit wider than an index so SIZE itself is representable when SIZE is a power of two.
    localparam logic [BIT:0]  IDX_LIMIT = (BIT + 1)'(SIZE);
    localparam logic [FW-1:0] LAST_FILL = FW'(K - 1);
    localparam logic [FW-1:0] FULL_FILL = FW'(K);

    state_t             state_q, state_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [K*BIT-1:0]   string_q, string_d;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            fill_q   <= '0;
            string_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            string_q <= string_d;
            err_q    <= err_d;
        end
    end

    // Flush outranks both the input accept and the output handshake.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        string_d = string_q;
        err_d    = err_q;
        unique case (state_q)
            COLLECT: begin
                if (flush) begin
                    fill_d = '0;
                end else if (in_valid) begin
                    for (int i = 0; i < K; i++) begin
                        if (fill_q == FW'(i)) begin
                            string_d[i*BIT +: BIT] = in_index;
                        end
                    end
                    if ({1'b0, in_index} >= IDX_LIMIT) begin
                        err_d = 1'b1;
                    end
                    if (fill_q == LAST_FILL) begin
                        fill_d  = FULL_FILL;
                        state_d = FULL;
                    end else begin
                        fill_d = fill_q + FW'(1);
                    end
                end
            end
            FULL: begin
                if (flush || out_ready) begin
                    fill_d  = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                fill_d  = '0;
                state_d = COLLECT;
            end
        endcase
    end

    assign in_ready   = (state_q == COLLECT);
    assign out_valid  = (state_q == FULL);
    assign string_out = string_q;
    assign fill       = fill_q;
    assign err        = err_q;

endmodule
